// File: rtl/b13_pkg.sv
// b13_pkg: shared FSM encodings and timing defaults for the serial receiver
package b13_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;
  localparam int BIT_PERIOD_DEF = 106;
endpackage

// File: rtl/b13_rx_fifo.sv
// b13_rx_fifo: 2-entry byte FIFO; a push while full is accepted only alongside a pop
module b13_rx_fifo (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);
  logic [7:0] mem_q [2];
  logic [7:0] mem_d [2];
  logic       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, do_push, do_pop;
  logic [1:0] count_q, count_d;
  assign full    = count_q == 2'd2;
  assign empty   = count_q == 2'd0;
  assign rd_data = mem_q[rd_ptr_q];
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = wr_data;
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q + 2'(do_push) - 2'(do_pop);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/b13_serial_rx.sv
// b13_serial_rx: mid-bit sampling 8N1 receiver feeding a 2-entry buffer
module b13_serial_rx
  import b13_pkg::*;
#(
  parameter int BIT_PERIOD  = BIT_PERIOD_DEF,
  parameter int HALF_PERIOD = BIT_PERIOD / 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_in,
  output logic       dsr,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       frame_err,
  output logic       overrun
);
  localparam logic [6:0] BIT_LAST  = 7'(BIT_PERIOD - 1);
  localparam logic [6:0] HALF_LAST = 7'(HALF_PERIOD - 1);
  state_t     state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic [6:0] timer_q, timer_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic       push_q, push_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic       rxs, full, empty, blocked;
  assign rxs       = sync_q[1];
  assign dsr       = !full;
  assign rd_valid  = !empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  // A pop on the stop-sample edge frees the slot the delayed push will use
  assign blocked   = full && !rd_ready;
  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], rx_in};
    timer_d     = timer_q + 7'd1;
    idx_d       = idx_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = 7'd0;
        state_d = rxs ? IDLE : START;
      end
      START: if (timer_q == HALF_LAST) begin
        timer_d = 7'd0;
        idx_d   = 3'd0;
        state_d = rxs ? IDLE : DATA;
      end
      DATA: if (timer_q == BIT_LAST) begin
        timer_d = 7'd0;
        shift_d = {shift_q[6:0], rxs};
        idx_d   = idx_q + 3'd1;
        state_d = (idx_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (timer_q == BIT_LAST) begin
        timer_d     = 7'd0;
        state_d     = IDLE;
        push_d      = rxs && !blocked;
        overrun_d   = rxs && blocked;
        frame_err_d = !rxs;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      timer_q     <= 7'd0;
      idx_q       <= 3'd0;
      shift_q     <= 8'd0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end
  // shift_q is stable for the push edge: the next frame cannot reach DATA that soon
  b13_rx_fifo u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push_q),
    .pop     (rd_ready),
    .wr_data (shift_q),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );
endmodule

// File: tb/tb_b13_serial_rx.sv
// tb_b13_serial_rx: directed frame table plus hand sequences for buffer and reset corners
module tb_b13_serial_rx;
  import b13_pkg::*;
  localparam int BP = 106;
  logic       clock = 1'b0, reset = 1'b1, rx_in = 1'b1, rd_ready = 1'b0;
  logic       dsr, rd_valid, frame_err, overrun;
  logic [7:0] rd_data;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, cyc0 = 0, rise_cyc = -1;
  int ferr_n = 0, ovr_n = 0, both_n = 0;
  logic rv_prev = 1'b0;
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    int         exp_ferr;
  } vec_t;
  vec_t tbl[7];
  b13_serial_rx #(.BIT_PERIOD(BP), .HALF_PERIOD(BP / 2)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_in     (rx_in),
    .dsr       (dsr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    ferr_n  <= ferr_n + int'(frame_err);
    ovr_n   <= ovr_n + int'(overrun);
    both_n  <= both_n + int'(frame_err && overrun);
    if (rd_valid && !rv_prev) rise_cyc <= cyc;
    rv_prev <= rd_valid;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop, input int ready_edge);
    logic [9:0] bits;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i + 1] = d[7 - i];
    bits[9] = stop;
    @(posedge clock);
    #1;
    cyc0 = cyc;
    for (int c = 0; c < 10 * BP; c++) begin
      rx_in    = bits[c / BP];
      rd_ready = (c + 1 == ready_edge);
      @(posedge clock);
      #1;
    end
    rx_in    = 1'b1;
    rd_ready = 1'b0;
    repeat (4) @(posedge clock);
    #1;
  endtask
  task automatic pop_chk(input logic [7:0] exp);
    chk("pop_valid", 32'(rd_valid), 32'd1);
    chk("pop_data", 32'(rd_data), 32'(exp));
    rd_ready = 1'b1;
    @(posedge clock);
    #1;
    rd_ready = 1'b0;
  endtask
  initial begin
    int f0, o0;
    tbl[0] = '{8'hA5, 1'b1, 1'b1, 0};
    tbl[1] = '{8'h3C, 1'b0, 1'b0, 1};
    tbl[2] = '{8'h00, 1'b1, 1'b1, 0};
    tbl[3] = '{8'hFF, 1'b1, 1'b1, 0};
    tbl[4] = '{8'h80, 1'b1, 1'b1, 0};
    tbl[5] = '{8'h01, 1'b1, 1'b1, 0};
    tbl[6] = '{8'h5A, 1'b0, 1'b0, 1};
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_dsr", 32'(dsr), 32'd1);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    // latency: rd_valid rises 1011 edges after the start bit is driven
    send_frame(8'hA5, 1'b1, 0);
    chk("lat_rise", 32'(rise_cyc - cyc0), 32'd1011);
    pop_chk(8'hA5);
    for (int i = 0; i < 7; i++) begin
      f0 = ferr_n;
      o0 = ovr_n;
      send_frame(tbl[i].data, tbl[i].stop, 0);
      chk($sformatf("tbl%0d_valid", i), 32'(rd_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_ferr", i), 32'(ferr_n - f0), 32'(tbl[i].exp_ferr));
      chk($sformatf("tbl%0d_ovr", i), 32'(ovr_n - o0), 32'd0);
      if (tbl[i].exp_valid) pop_chk(tbl[i].data);
      chk($sformatf("tbl%0d_empty", i), 32'(rd_valid), 32'd0);
    end
    // glitch shorter than half a bit aborts START
    rx_in = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    rx_in = 1'b1;
    repeat (200) @(posedge clock);
    #1;
    chk("glitch_state", 32'(dut.state_q), 32'(IDLE));
    chk("glitch_valid", 32'(rd_valid), 32'd0);
    // overrun on the third frame with no consumer
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    chk("full_dsr", 32'(dsr), 32'd0);
    f0 = ferr_n;
    o0 = ovr_n;
    send_frame(8'h33, 1'b1, 0);
    chk("ovr_pulse", 32'(ovr_n - o0), 32'd1);
    chk("ovr_noferr", 32'(ferr_n - f0), 32'd0);
    pop_chk(8'h11);
    pop_chk(8'h22);
    chk("ovr_empty", 32'(rd_valid), 32'd0);
    chk("ovr_dsr", 32'(dsr), 32'd1);
    // pop on the stop-sample edge makes room for the frame
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    o0 = ovr_n;
    send_frame(8'h44, 1'b1, 1010);
    chk("sim_noovr", 32'(ovr_n - o0), 32'd0);
    pop_chk(8'h22);
    pop_chk(8'h44);
    chk("sim_empty", 32'(rd_valid), 32'd0);
    // frame error with one entry held leaves the buffer alone
    send_frame(8'h77, 1'b1, 0);
    f0 = ferr_n;
    send_frame(8'h3C, 1'b0, 0);
    chk("ferr_pulse", 32'(ferr_n - f0), 32'd1);
    chk("ferr_dsr", 32'(dsr), 32'd1);
    pop_chk(8'h77);
    chk("ferr_empty", 32'(rd_valid), 32'd0);
    // reset mid-frame discards the partial byte and the held entry
    send_frame(8'h5A, 1'b1, 0);
    f0 = ferr_n;
    o0 = ovr_n;
    fork
      send_frame(8'hFF, 1'b1, 0);
      begin
        repeat (5 * BP + 50) @(posedge clock);
        #2;
        reset = 1'b1;
        @(negedge clock);
        chk("mrst_dsr", 32'(dsr), 32'd1);
        chk("mrst_valid", 32'(rd_valid), 32'd0);
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
      end
    join
    chk("mrst_after_valid", 32'(rd_valid), 32'd0);
    chk("mrst_ferr", 32'(ferr_n - f0), 32'd0);
    chk("mrst_ovr", 32'(ovr_n - o0), 32'd0);
    send_frame(8'h01, 1'b1, 0);
    pop_chk(8'h01);
    chk("never_both", 32'(both_n), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
